// File: rtl/home_pkg.sv
// Shared definitions for the home event scheduler: event bit positions,
// display codes and the scheduler state type.
package home_pkg;

  // Bit positions of each event inside the pending/grant vectors
  localparam int EV_FDOOR  = 5;
  localparam int EV_RDOOR  = 4;
  localparam int EV_ALARM  = 3;
  localparam int EV_WINDOW = 2;
  localparam int EV_HEATER = 1;
  localparam int EV_COOLER = 0;

  localparam int NUM_EVENTS = 6;

  // One-hot mask of the alarm event, used for preemption
  localparam logic [NUM_EVENTS-1:0] MASK_ALARM = 6'b00_1000;

  // Codes shown on the status display
  localparam logic [2:0] CODE_IDLE   = 3'd0;
  localparam logic [2:0] CODE_FDOOR  = 3'd1;
  localparam logic [2:0] CODE_RDOOR  = 3'd2;
  localparam logic [2:0] CODE_ALARM  = 3'd3;
  localparam logic [2:0] CODE_WINDOW = 3'd4;
  localparam logic [2:0] CODE_HEATER = 3'd5;
  localparam logic [2:0] CODE_COOLER = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/event_prio_enc.sv
// Fixed-priority encoder: picks the most urgent pending event
// (alarm, fdoor, rdoor, window, heater, cooler) and reports its one-hot
// select, its display code and whether anything was pending at all.
module event_prio_enc
  import home_pkg::*;
(
  input  logic [NUM_EVENTS-1:0] req,
  output logic [NUM_EVENTS-1:0] grant,
  output logic [2:0]            code,
  output logic                  valid
);

  // Priority chain, highest urgency tested first
  always_comb begin
    grant = '0;
    code  = CODE_IDLE;
    valid = |req;
    if (req[EV_ALARM]) begin
      grant[EV_ALARM] = 1'b1;
      code            = CODE_ALARM;
    end else if (req[EV_FDOOR]) begin
      grant[EV_FDOOR] = 1'b1;
      code            = CODE_FDOOR;
    end else if (req[EV_RDOOR]) begin
      grant[EV_RDOOR] = 1'b1;
      code            = CODE_RDOOR;
    end else if (req[EV_WINDOW]) begin
      grant[EV_WINDOW] = 1'b1;
      code             = CODE_WINDOW;
    end else if (req[EV_HEATER]) begin
      grant[EV_HEATER] = 1'b1;
      code             = CODE_HEATER;
    end else if (req[EV_COOLER]) begin
      grant[EV_COOLER] = 1'b1;
      code             = CODE_COOLER;
    end
  end

endmodule

// File: rtl/home_event_scheduler.sv
// Home event scheduler: latches sensor events as pending requests and
// serves one actuator at a time for HOLD_CYCLES cycles. A pending fire
// alarm preempts any other service and requeues the interrupted event.
module home_event_scheduler
  import home_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int TEMP_LOW    = 50,
  parameter int TEMP_HIGH   = 70
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  SFD,
  input  logic                  SRD,
  input  logic                  SFA,
  input  logic                  SW,
  input  logic [6:0]            ST,
  output logic [NUM_EVENTS-1:0] grant,
  output logic [2:0]            display,
  output logic                  busy,
  output logic [NUM_EVENTS-1:0] pending
);

  // Counter holds remaining service cycles after the current one
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0] T_LOW  = 7'(TEMP_LOW);
  localparam logic [6:0] T_HIGH = 7'(TEMP_HIGH);

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [NUM_EVENTS-1:0]   grant_next;
  logic [2:0]              display_next;
  logic [NUM_EVENTS-1:0]   pending_next;
  logic [NUM_EVENTS-1:0]   events;
  logic [NUM_EVENTS-1:0]   clear_bits;
  logic [NUM_EVENTS-1:0]   requeue_bits;
  logic [3:0]              sensors;
  logic [3:0]              prev_sensors;

  logic [NUM_EVENTS-1:0]   enc_grant;
  logic [2:0]              enc_code;
  logic                    enc_valid;

  assign sensors = {SFD, SRD, SFA, SW};
  assign busy    = (state == SERVE);

  event_prio_enc u_prio (
    .req   (pending),
    .grant (enc_grant),
    .code  (enc_code),
    .valid (enc_valid)
  );

  // Door/alarm/window fire on rising edges; temperature requests are levels
  always_comb begin
    events       = '0;
    events[5:2]  = sensors & ~prev_sensors;
    events[EV_HEATER] = (ST < T_LOW);
    events[EV_COOLER] = (ST > T_HIGH);
  end

  // Next-state logic: grant from IDLE, hold/countdown or alarm preemption in SERVE
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    grant_next   = grant;
    display_next = display;
    clear_bits   = '0;
    requeue_bits = '0;
    case (state)
      IDLE: begin
        grant_next   = '0;
        display_next = CODE_IDLE;
        if (En && enc_valid) begin
          state_next   = SERVE;
          grant_next   = enc_grant;
          display_next = enc_code;
          clear_bits   = enc_grant;
          cnt_next     = CNT_LOAD;
        end
      end
      SERVE: begin
        if (pending[EV_ALARM] && !grant[EV_ALARM]) begin
          grant_next   = MASK_ALARM;
          display_next = CODE_ALARM;
          cnt_next     = CNT_LOAD;
          clear_bits   = MASK_ALARM;
          requeue_bits = grant;
        end else if (cnt == '0) begin
          state_next   = IDLE;
          grant_next   = '0;
          display_next = CODE_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        grant_next   = '0;
        display_next = CODE_IDLE;
      end
    endcase
    // New events win over a clear of the same bit
    pending_next = (pending & ~clear_bits) | requeue_bits | events;
  end

  // State, counter, outputs and sensor history; reset overrides everything
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      grant        <= '0;
      display      <= CODE_IDLE;
      pending      <= '0;
      prev_sensors <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      grant        <= grant_next;
      display      <= display_next;
      pending      <= pending_next;
      prev_sensors <= sensors;
    end
  end

endmodule

// File: tb/tb_home_event_scheduler.sv
// Bench for home_event_scheduler: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural model.
module tb_home_event_scheduler;

  localparam int HOLD = 4;
  localparam int TLOW = 50;
  localparam int THIGH = 70;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       En;
  logic       SFD;
  logic       SRD;
  logic       SFA;
  logic       SW;
  logic [6:0] ST;
  logic [5:0] grant;
  logic [2:0] display;
  logic       busy;
  logic [5:0] pending;

  int checks = 0;
  int errors = 0;

  // Model state: pending flags per event index, event in service (-1 none),
  // number of cycles the current service has been visible so far
  bit m_pend[6];
  int m_event;
  int m_age;
  bit m_prev_fd, m_prev_rd, m_prev_fa, m_prev_sw;
  int prio_order[6] = '{3, 5, 4, 2, 1, 0};

  home_event_scheduler #(
    .HOLD_CYCLES (HOLD),
    .TEMP_LOW    (TLOW),
    .TEMP_HIGH   (THIGH)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .En      (En),
    .SFD     (SFD),
    .SRD     (SRD),
    .SFA     (SFA),
    .SW      (SW),
    .ST      (ST),
    .grant   (grant),
    .display (display),
    .busy    (busy),
    .pending (pending)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  task automatic applyStimulus(input bit rst, input bit en, input bit fd,
                               input bit rd, input bit fa, input bit sw,
                               input int temp);
    Rst = rst;
    En  = en;
    SFD = fd;
    SRD = rd;
    SFA = fa;
    SW  = sw;
    ST  = 7'(temp);
  endtask

  // Advance the model by one clock edge using the inputs present at the edge
  task automatic modelStep();
    bit ev[6];
    int pick;
    if (Rst) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_event = -1;
      m_age = 0;
      m_prev_fd = 0; m_prev_rd = 0; m_prev_fa = 0; m_prev_sw = 0;
      return;
    end
    ev[5] = SFD && !m_prev_fd;
    ev[4] = SRD && !m_prev_rd;
    ev[3] = SFA && !m_prev_fa;
    ev[2] = SW && !m_prev_sw;
    ev[1] = (int'(ST) < TLOW);
    ev[0] = (int'(ST) > THIGH);
    if (m_event >= 0) begin
      if (m_pend[3] && m_event != 3) begin
        m_pend[3] = 0;
        m_pend[m_event] = 1;
        m_event = 3;
        m_age = 1;
      end else if (m_age >= HOLD) begin
        m_event = -1;
        m_age = 0;
      end else begin
        m_age++;
      end
    end else if (En) begin
      pick = -1;
      foreach (prio_order[i])
        if (pick < 0 && m_pend[prio_order[i]]) pick = prio_order[i];
      if (pick >= 0) begin
        m_pend[pick] = 0;
        m_event = pick;
        m_age = 1;
      end
    end
    foreach (ev[i]) if (ev[i]) m_pend[i] = 1;
    m_prev_fd = SFD; m_prev_rd = SRD; m_prev_fa = SFA; m_prev_sw = SW;
  endtask

  task automatic checkValue(input string tag, input logic [5:0] observed,
                            input logic [5:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Compare all DUT outputs against the model
  task automatic checkOutput();
    logic [5:0] exp_grant;
    logic [5:0] exp_pend;
    logic [2:0] exp_disp;
    logic       exp_busy;
    exp_grant = '0;
    exp_disp  = '0;
    exp_busy  = 1'b0;
    if (m_event >= 0) begin
      exp_grant[m_event] = 1'b1;
      exp_disp = 3'(6 - m_event);
      exp_busy = 1'b1;
    end
    foreach (m_pend[i]) exp_pend[i] = m_pend[i];
    checkValue("grant", grant, exp_grant);
    checkValue("display", {3'b000, display}, {3'b000, exp_disp});
    checkValue("busy", {5'b0, busy}, {5'b0, exp_busy});
    checkValue("pending", pending, exp_pend);
  endtask

  task automatic tick();
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    m_event = -1;
    m_age = 0;
    applyStimulus(1, 1, 0, 0, 0, 0, 60);
    repeat (2) tick();
    checkValue("reset_grant", grant, 6'b000000);
    checkValue("reset_pending", pending, 6'b000000);
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    tick();

    $display("[TB] single front door event");
    applyStimulus(0, 1, 1, 0, 0, 0, 60);
    tick();
    checkValue("fdoor_pending", pending, 6'b100000);
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    tick();
    checkValue("fdoor_grant", grant, 6'b100000);
    repeat (6) tick();

    $display("[TB] simultaneous front door and window");
    applyStimulus(0, 1, 1, 0, 0, 1, 60);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    repeat (13) tick();

    $display("[TB] alarm preempts rear door");
    applyStimulus(0, 1, 0, 1, 0, 0, 60);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    repeat (2) tick();
    applyStimulus(0, 1, 0, 0, 1, 0, 60);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    tick();
    checkValue("alarm_grant", grant, 6'b001000);
    repeat (12) tick();

    $display("[TB] temperature sweep");
    applyStimulus(0, 1, 0, 0, 0, 0, 49);
    repeat (12) tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 50);
    repeat (8) tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 70);
    repeat (6) tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 71);
    repeat (8) tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    repeat (8) tick();

    $display("[TB] enable low blocks grants");
    applyStimulus(0, 0, 0, 1, 0, 0, 60);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 60);
    repeat (10) tick();
    checkValue("en_low_grant", grant, 6'b000000);
    applyStimulus(0, 1, 0, 0, 0, 0, 60);
    tick();
    checkValue("en_high_grant", grant, 6'b010000);
    repeat (6) tick();

    $display("[TB] reset during service with front door held");
    applyStimulus(0, 1, 1, 0, 0, 0, 60);
    repeat (4) tick();
    applyStimulus(1, 1, 1, 0, 0, 0, 60);
    tick();
    checkValue("rst_grant", grant, 6'b000000);
    applyStimulus(0, 1, 1, 0, 0, 0, 60);
    repeat (14) tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 11) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                                : int'($urandom_range(48, 72)));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
